weight_sram_arbiter: RTL and testbench

WEIGHT_SRAM_ARBITER -- requirements
Module: weight_sram_arbiter

---
 rtl/weight_sram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_weight_sram_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_sram_arbiter.sv
// -----------------------------------------------------------------------------
// weight_sram_arbiter
//
// Shares one single-port weight SRAM between the weight loader (write side)
// and four compute engines (read side: conv1, conv2, conv3, fc).
//
// The loader always wins: a write request is granted combinationally in the
// same cycle and pre-empts any read. Reads are arbitrated with a bursting
// round-robin. The current owner keeps the SRAM for up to BURST_MAX
// consecutive beats while it keeps requesting. After that, or when it drops
// its request, the search moves on starting from the next requester. Read
// data comes back one cycle after the grant. It is tagged one-hot with the
// requester it belongs to.
//
// Parameters
//   AW         SRAM address width
//   DW         SRAM word width
//   BURST_MAX  maximum consecutive read beats per grant (>= 1)
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst_n       synchronous active-low reset
//   wr_req      loader write request
//   wr_addr     loader write address
//   wr_data     loader write data
//   wr_gnt      write accepted this cycle
//   rd_req      read requests: bit0 conv1, bit1 conv2, bit2 conv3, bit3 fc
//   rd_addr     read addresses, requester i at [i*AW +: AW]
//   rd_gnt      one-hot read grant, accepted this cycle
//   rd_valid    one-hot: rd_data belongs to requester i
//   rd_data     read data (zero when no rd_valid bit is set)
//   sram_me     SRAM enable
//   sram_we     SRAM write enable
//   sram_addr   SRAM address
//   sram_wdata  SRAM write data
//   sram_rdata  SRAM read data, valid one cycle after a read access
//   owner       current burst owner (debug)
// -----------------------------------------------------------------------------
module weight_sram_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 72,
  parameter int BURST_MAX = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_req,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_gnt,
  input  logic [3:0]      rd_req,
  input  logic [4*AW-1:0] rd_addr,
  output logic [3:0]      rd_gnt,
  output logic [3:0]      rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            sram_me,
  output logic            sram_we,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata,
  output logic [1:0]      owner
);

  // Beat counter wide enough to hold BURST_MAX for the end-of-burst compare.
  localparam int CW = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX);

  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] cnt_inc;
  logic          burst_active;

  logic          hold;
  logic          rr_found;
  logic [1:0]    rr_idx;
  logic [1:0]    cand;
  logic          win_found;
  logic [1:0]    win_idx;
  logic          grant_wr;
  logic          grant_rd;

  logic [3:0]    rd_vld_p1;

  // ---------------------------------------------------------------------------
  // Stage p0: winner selection and same-cycle grant / SRAM drive
  // ---------------------------------------------------------------------------

  // The owner keeps the SRAM only while its burst is open and it still asks.
  assign hold = burst_active & rd_req[owner];

  // Round-robin search from owner+1 upward with wrap. The fourth candidate
  // is the owner itself. This lets a sole requester be re-granted right
  // after its burst closes, with no idle cycle in between.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = owner;
    cand     = owner;
    for (int k = 1; k <= 4; k++) begin
      cand = owner + 2'(k);
      if (!rr_found && rd_req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign win_found = hold | rr_found;
  assign win_idx   = hold ? owner : rr_idx;

  // Reset forces every grant low regardless of requests.
  assign grant_wr = rst_n & wr_req;
  assign grant_rd = rst_n & ~wr_req & win_found;

  assign cnt_inc = burst_cnt + CW'(1);

  always_comb begin
    wr_gnt     = 1'b0;
    rd_gnt     = 4'b0000;
    sram_me    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_wr) begin
      wr_gnt     = 1'b1;
      sram_me    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = wr_addr;
      sram_wdata = wr_data;
    end else if (grant_rd) begin
      rd_gnt          = 4'b0000;
      rd_gnt[win_idx] = 1'b1;
      sram_me         = 1'b1;
      sram_addr       = rd_addr[win_idx*AW +: AW];
    end
  end

  // Burst bookkeeping. A write cycle touches none of it, so a pre-empted
  // owner picks up exactly where it left off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner        <= 2'd3;  // first search after reset starts at conv1
      burst_cnt    <= '0;
      burst_active <= 1'b0;
    end else if (grant_rd) begin
      if (hold) begin
        if (cnt_inc == BURST_LAST) begin
          burst_active <= 1'b0;
          burst_cnt    <= '0;
        end else begin
          burst_cnt <= cnt_inc;
        end
      end else begin
        // New burst. This also covers the case where the owner dropped its
        // request this cycle and another requester took over.
        owner <= win_idx;
        if (BURST_MAX == 1) begin
          burst_active <= 1'b0;
          burst_cnt    <= '0;
        end else begin
          burst_active <= 1'b1;
          burst_cnt    <= CW'(1);
        end
      end
    end else if (!wr_req && burst_active && !rd_req[owner]) begin
      // Owner dropped its request and nobody else is waiting.
      burst_active <= 1'b0;
      burst_cnt    <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: read return, aligned with the SRAM's one-cycle read latency
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_p1 <= 4'b0000;
    end else begin
      rd_vld_p1 <= rd_gnt;
    end
  end

  assign rd_valid = rd_vld_p1;
  assign rd_data  = (|rd_vld_p1) ? sram_rdata : '0;

endmodule

// File: tb/tb_weight_sram_arbiter.sv
module tb_weight_sram_arbiter;

  localparam int AW = 10;
  localparam int DW = 72;
  localparam int BM = 9;

  logic            clk;
  logic            rst_n;
  logic            wr_req;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_gnt;
  logic [3:0]      rd_req;
  logic [4*AW-1:0] rd_addr;
  logic [3:0]      rd_gnt;
  logic [3:0]      rd_valid;
  logic [DW-1:0]   rd_data;
  logic            sram_me;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [DW-1:0]   sram_rdata;
  logic [1:0]      owner;

  weight_sram_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .sram_me(sram_me), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word[addr] = addr until overwritten, one-cycle read latency.
  logic [DW-1:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
  always @(posedge clk) begin
    if (sram_me) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  // Bench-side shadow of the memory contents, updated from bench stimulus.
  logic [DW-1:0] exp_mem [1024];

  typedef struct {
    logic [3:0]    v;
    logic [DW-1:0] d;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string      name;
    logic       wr;
    logic [3:0] req;
    logic       exp_wg;
    logic [3:0] exp_rg;
    int         exp_owner;
  } vec_t;
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check same-cycle outputs at the
  // falling edge, then after the rising edge pop the expected read return.
  task automatic cyc(input string tag, input logic rst, input logic wr,
                     input logic [3:0] req, input logic exp_wg,
                     input logic [3:0] exp_rg, input int exp_owner);
    sb_t           e;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    rst_n  = rst;
    wr_req = wr;
    rd_req = req;
    #4;
    ea   = '0;
    ewd  = '0;
    e.v  = exp_rg;
    e.d  = '0;
    if (exp_wg) begin
      ea  = wr_addr;
      ewd = wr_data;
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_rg[i]) begin
        ea  = rd_addr[i*AW +: AW];
        e.d = exp_mem[ea];
      end
    end
    chk({tag, ".wr_gnt"},     DW'(wr_gnt),    DW'(exp_wg));
    chk({tag, ".rd_gnt"},     DW'(rd_gnt),    DW'(exp_rg));
    chk({tag, ".sram_me"},    DW'(sram_me),   DW'(exp_wg | (|exp_rg)));
    chk({tag, ".sram_we"},    DW'(sram_we),   DW'(exp_wg));
    chk({tag, ".sram_addr"},  DW'(sram_addr), DW'(ea));
    chk({tag, ".sram_wdata"}, sram_wdata,     ewd);
    sbq.push_back(e);
    if (exp_wg) exp_mem[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".rd_valid"}, DW'(rd_valid), DW'(e.v));
    chk({tag, ".rd_data"},  rd_data,       e.d);
    if (exp_owner >= 0) chk({tag, ".owner"}, DW'(owner), DW'(exp_owner));
  endtask

  task automatic do_reset();
    cyc("rst", 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) exp_mem[i] = DW'(i);
    rst_n   = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 4'b0000;
    wr_addr = AW'(5);
    wr_data = DW'(72'h0AB);
    rd_addr = {AW'(300), AW'(200), AW'(100), AW'(50)};

    vecs[0] = '{"wr_prio", 1'b1, 4'b1111, 1'b1, 4'b0000, 3};
    vecs[1] = '{"idle",    1'b0, 4'b0000, 1'b0, 4'b0000, 3};
    vecs[2] = '{"rd_c1",   1'b0, 4'b0001, 1'b0, 4'b0001, 0};
    vecs[3] = '{"rd_fc",   1'b0, 4'b1000, 1'b0, 4'b1000, 3};
    vecs[4] = '{"rr_skip", 1'b0, 4'b1100, 1'b0, 4'b0100, 2};
    vecs[5] = '{"rr_c2",   1'b0, 4'b1010, 1'b0, 4'b0010, 1};
    vecs[6] = '{"rr_all",  1'b0, 4'b1111, 1'b0, 4'b0001, 0};
    vecs[7] = '{"wr_only", 1'b1, 4'b0000, 1'b1, 4'b0000, 3};

    @(posedge clk);
    #1;

    // Grants held low during reset even with every request up.
    cyc("in_rst0", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 3);
    cyc("in_rst1", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 3);

    // Single-cycle vectors, each from the reset state.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      cyc(vecs[v].name, 1'b1, vecs[v].wr, vecs[v].req,
          vecs[v].exp_wg, vecs[v].exp_rg, vecs[v].exp_owner);
    end

    // Write then read of the same address returns the new word.
    do_reset();
    wr_addr = AW'(7);
    wr_data = 72'h12_3456_789A_BCDE_F0FF;
    cyc("raw_wr", 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 3);
    rd_addr[0 +: AW] = AW'(7);
    cyc("raw_rd", 1'b1, 1'b0, 4'b0001, 1'b0, 4'b0001, 0);
    rd_addr[0 +: AW] = AW'(50);

    // conv1 pre-empted at beat 3 by a one-cycle write, resumes at beat 4,
    // ends after beat 9; conv2 follows.
    do_reset();
    wr_addr = AW'(9);
    wr_data = DW'(72'h55);
    for (int b = 1; b <= 3; b++) cyc("pre_a", 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0001, 0);
    cyc("pre_wr", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 0);
    for (int b = 4; b <= 9; b++) cyc("pre_b", 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0001, 0);
    cyc("pre_next", 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0010, 1);

    // Full round robin with all four requesting.
    do_reset();
    for (int k = 0; k < 4 * BM + 1; k++) begin
      cyc("rr", 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0001 << ((k / BM) % 4), (k / BM) % 4);
    end

    // conv2 drops after 2 beats; conv3 takes over in the drop cycle and
    // gets a full fresh burst of 9 before fc.
    do_reset();
    cyc("drop_c2", 1'b1, 1'b0, 4'b1110, 1'b0, 4'b0010, 1);
    cyc("drop_c2", 1'b1, 1'b0, 4'b1110, 1'b0, 4'b0010, 1);
    for (int b = 1; b <= BM; b++) cyc("drop_c3", 1'b1, 1'b0, 4'b1100, 1'b0, 4'b0100, 2);
    cyc("drop_fc", 1'b1, 1'b0, 4'b1100, 1'b0, 4'b1000, 3);

    // fc reads 480, 481 back to back.
    do_reset();
    rd_addr[3*AW +: AW] = AW'(480);
    cyc("lat_480", 1'b1, 1'b0, 4'b1000, 1'b0, 4'b1000, 3);
    rd_addr[3*AW +: AW] = AW'(481);
    cyc("lat_481", 1'b1, 1'b0, 4'b1000, 1'b0, 4'b1000, 3);
    cyc("lat_idle", 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 3);
    rd_addr[3*AW +: AW] = AW'(300);

    // Reset mid-burst with a read in flight.
    do_reset();
    for (int b = 0; b < 4; b++) cyc("mid_burst", 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0001, 0);
    cyc("mid_rst", 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 3);
    cyc("post_rst", 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0001, 0);

    // Sole requester: 20 grants in a row across burst boundaries.
    do_reset();
    for (int k = 0; k < 20; k++) cyc("sole_c3", 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0100, 2);
    cyc("sole_end", 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
